// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks a register/value ROM and issues SCCB writes,
// with NACK retries, delay entries and an end marker.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start after reset
// FETCH     | rom_en high for one cycle, ROM registers the word
// DECODE    | classify word: end marker, delay marker or register write
// SEND      | sccb_valid high until the master accepts
// WAIT_DONE | waiting for the master to report completion / NACK
// DELAY     | counting down DELAY_CYCLES
// DONE      | run finished, done held until the next start
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    output logic        rom_en,
    input  logic [15:0] rom_dout,
    output logic        sccb_valid,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_ready,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    localparam logic [15:0] WORD_END   = 16'hFFFF;
    localparam logic [15:0] WORD_DELAY = 16'hFFF0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_DELAY     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [DW-1:0] delay_cnt;
    logic          advance;

    always_comb begin
        rom_en  = (state == S_FETCH);
        busy    = (state != S_IDLE) && (state != S_DONE);
        advance = 1'b0;
        if (state == S_WAIT_DONE && sccb_done && (!sccb_nack || retry_cnt == RETRY_MAX))
            advance = 1'b1;
        if (state == S_DELAY && delay_cnt == '0)
            advance = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            retry_cnt  <= '0;
            delay_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr  <= '0;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        retry_cnt <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (rom_dout == WORD_END) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (rom_dout == WORD_DELAY) begin
                        delay_cnt <= DELAY_LOAD;
                        state     <= S_DELAY;
                    end else begin
                        sccb_reg   <= rom_dout[15:8];
                        sccb_data  <= rom_dout[7:0];
                        sccb_valid <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sccb_ready) begin
                        sccb_valid <= 1'b0;
                        state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            retry_cnt <= '0;
                        end else if (retry_cnt < RETRY_MAX) begin
                            // same reg/val are still latched, just re-raise valid
                            retry_cnt  <= retry_cnt + RW'(1);
                            sccb_valid <= 1'b1;
                            state      <= S_SEND;
                        end else begin
                            err       <= 1'b1;
                            retry_cnt <= '0;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt != '0)
                        delay_cnt <= delay_cnt - DW'(1);
                end
                default: state <= S_IDLE;
            endcase

            // last ROM address terminates the run instead of wrapping
            if (advance) begin
                if (rom_addr == 8'hFF) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    rom_addr <= rom_addr + 8'd1;
                    state    <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: ROM and SCCB master models, a scoreboard built
// from the ROM contents, and a per-cycle compare process.
module tb_ov7670_config_sequencer;

    localparam int DC = 10;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [15:0] rom_dout = '0;
    logic        sccb_valid;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready = 1'b1;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    ov7670_config_sequencer #(.DELAY_CYCLES(DC), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_dout(rom_dout),
        .sccb_valid(sccb_valid), .sccb_reg(sccb_reg), .sccb_data(sccb_data),
        .sccb_ready(sccb_ready), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy), .done(done), .err(err)
    );

    logic [15:0] rom [256];
    always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

    int n_checks = 0;
    int n_pass   = 0;

    int  lat = 5;
    bit  nack_all = 1'b0;
    int  stall_left = 0;
    bit  inject_done = 1'b0;
    int  pend = 0;

    logic       pre_valid = 1'b0, pre_ready = 1'b0;
    logic [7:0] pre_reg = '0, pre_data = '0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    bit          exp_err;
    logic [7:0]  exp_end;
    int          exp_total;

    int          n_xfer = 0;
    int          stall_cycles = 0;
    int          cyc = 0;
    bit          fetch_seen = 1'b0;
    logic [7:0]  last_fetch_addr = '0;
    int          last_fetch_cyc = 0;
    int          last_delay_gap = 0;
    logic [15:0] first_xfer = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Expected transfer list straight from the ROM walk rules.
    task automatic build_expect();
        int reps;
        int end_a;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_total = 0;
        end_a     = 255;
        reps      = nack_all ? MR + 1 : 1;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                end_a = a;
                break;
            end
            if (rom[a] != 16'hFFF0) begin
                for (int r = 0; r < reps; r++) exp_q.push_back(rom[a]);
                exp_total += reps;
                if (nack_all) exp_err = 1'b1;
            end
        end
        exp_end = 8'(end_a);
    endtask

    // SCCB master model, drives its inputs on the falling edge
    always @(negedge clk) begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (rst) pend = 0;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                sccb_done = 1'b1;
                sccb_nack = nack_all;
            end
        end
        if (inject_done) begin
            sccb_done   = 1'b1;
            inject_done = 1'b0;
        end
        if (sccb_valid === 1'b1 && stall_left > 0) begin
            sccb_ready = 1'b0;
            stall_left--;
        end else begin
            sccb_ready = 1'b1;
        end
        if (sccb_valid === 1'b1 && sccb_ready && !rst) pend = lat;
        pre_valid = sccb_valid;
        pre_ready = sccb_ready;
        pre_reg   = sccb_reg;
        pre_data  = sccb_data;
    end

    // compare process
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            chk("reset_outputs",
                32'({rom_addr, rom_en, sccb_valid, sccb_reg, sccb_data, busy, done, err}), 32'd0);
        end else begin
            if (pre_valid === 1'b1 && pre_ready === 1'b1) begin
                mon_exp = 16'hDEAD;
                if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
                if (n_xfer == 0) first_xfer = {pre_reg, pre_data};
                n_xfer++;
                chk("xfer_reg_data", 32'({pre_reg, pre_data}), 32'(mon_exp));
            end
            if (pre_valid === 1'b1 && pre_ready === 1'b0) begin
                stall_cycles++;
                chk("hold_while_stalled", 32'({sccb_valid, sccb_reg, sccb_data}),
                    32'({1'b1, pre_reg, pre_data}));
            end
            if (fetch_seen && rom[last_fetch_addr] == 16'hFFF0 && !rom_en)
                chk("no_valid_in_delay", 32'(sccb_valid), 32'd0);
            if (fetch_seen && cyc == last_fetch_cyc + 2 &&
                rom[last_fetch_addr] != 16'hFFFF && rom[last_fetch_addr] != 16'hFFF0)
                chk("decode_to_valid", 32'(sccb_valid), 32'd1);
            if (rom_en) begin
                if (fetch_seen) begin
                    chk("fetch_addr", 32'(rom_addr), 32'(last_fetch_addr + 8'd1));
                    if (rom[last_fetch_addr] == 16'hFFF0) begin
                        last_delay_gap = cyc - last_fetch_cyc;
                        chk("delay_fetch_gap", 32'(last_delay_gap), 32'(DC + 2));
                    end
                end else begin
                    chk("first_fetch_addr", 32'(rom_addr), 32'd0);
                end
                fetch_seen      = 1'b1;
                last_fetch_addr = rom_addr;
                last_fetch_cyc  = cyc;
            end
            chk("busy_done_exclusive", 32'(busy & done), 32'd0);
        end
    end

    task automatic fill_rom(input logic [15:0] w);
        fetch_seen = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic begin_run();
        build_expect();
        n_xfer         = 0;
        stall_cycles   = 0;
        last_delay_gap = 0;
        fetch_seen     = 1'b0;
        pulse_start();
    endtask

    task automatic wait_xfer(input int max_cyc);
        int n0;
        n0 = n_xfer;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #2;
            if (n_xfer > n0) break;
        end
        chk("xfer_seen", 32'(n_xfer > n0), 32'd1);
    endtask

    task automatic finish_run(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #2;
            if (done) break;
        end
        chk("run_done", 32'(done), 32'd1);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_err", 32'(err), 32'(exp_err));
        chk("run_rom_addr", 32'(rom_addr), 32'(exp_end));
        chk("run_xfer_count", 32'(n_xfer), 32'(exp_total));
        chk("run_exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string name);
        chk(name, 32'({rom_addr, rom_en, sccb_valid, sccb_reg, sccb_data, busy, done, err}), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_rom(16'hFFFF);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk_idle("idle_after_reset");

        // single write, second start while busy must be ignored
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280;
        begin_run();
        wait_xfer(100);
        pulse_start();
        finish_run(200);
        chk("t1_first_xfer", 32'(first_xfer), 32'h1280);
        chk("t1_xfer_count", 32'(n_xfer), 32'd1);
        chk("t1_rom_addr", 32'(rom_addr), 32'd1);

        // delay entry
        fill_rom(16'hFFFF);
        rom[0] = 16'hFFF0;
        begin_run();
        finish_run(100);
        chk("t2_delay_gap", 32'(last_delay_gap), 32'd12);
        chk("t2_xfer_count", 32'(n_xfer), 32'd0);

        // every transfer NACKed
        fill_rom(16'hFFFF);
        rom[0]   = 16'h1204;
        nack_all = 1'b1;
        begin_run();
        finish_run(300);
        nack_all = 1'b0;
        chk("t3_xfer_count", 32'(n_xfer), 32'd4);
        chk("t3_err", 32'(err), 32'd1);

        // ready stall with a stray done pulse in SEND
        fill_rom(16'hFFFF);
        rom[0]     = 16'h3456;
        rom[1]     = 16'h2A5B;
        stall_left = 20;
        begin_run();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (stall_cycles >= 5) break;
        end
        @(negedge clk); #1;
        inject_done = 1'b1;
        finish_run(300);
        chk("t4_stall_cycles", 32'(stall_cycles), 32'd20);
        chk("t4_xfer_count", 32'(n_xfer), 32'd2);
        chk("t4_err", 32'(err), 32'd0);

        // reset while waiting for done, then restart
        fill_rom(16'hFFFF);
        rom[0] = 16'h1280;
        begin_run();
        wait_xfer(100);
        @(negedge clk); #1;
        rst        = 1'b1;
        fetch_seen = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk_idle("t5_idle_after_reset");
        repeat (8) @(negedge clk);
        #1 chk_idle("t5_still_idle");
        begin_run();
        finish_run(200);
        chk("t5_xfer_count", 32'(n_xfer), 32'd1);

        // full ROM of writes, no end marker
        fill_rom(16'h1100);
        lat = 1;
        begin_run();
        finish_run(3000);
        chk("t6_xfer_count", 32'(n_xfer), 32'd256);
        chk("t6_rom_addr", 32'(rom_addr), 32'd255);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_no_wrap", 32'({rom_addr, busy, done}), 32'({8'd255, 1'b0, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
